// File: rtl/stage_envelope_pkg.sv
// Shared types for the envelope stage: voice-operator ID, envelope phase
// encoding, config parameter codes and the per-entry state record.
package stage_envelope_pkg;

    localparam int NUM_VOICE_OPS = 256;

    typedef logic [7:0] VoiceOperatorID_t;

    typedef enum logic [2:0] {
        PHASE_IDLE    = 3'd0,
        PHASE_P1      = 3'd1,
        PHASE_P2      = 3'd2,
        PHASE_P3      = 3'd3,
        PHASE_SUSTAIN = 3'd4,
        PHASE_RELEASE = 3'd5
    } EnvelopePhase_t;

    // Config parameter codes carried in i_ConfigWriteAddr[10:8].
    localparam logic [2:0] CFG_L1 = 3'd0;
    localparam logic [2:0] CFG_L2 = 3'd1;
    localparam logic [2:0] CFG_L3 = 3'd2;
    localparam logic [2:0] CFG_L4 = 3'd3;
    localparam logic [2:0] CFG_R1 = 3'd4;
    localparam logic [2:0] CFG_R2 = 3'd5;
    localparam logic [2:0] CFG_R3 = 3'd6;
    localparam logic [2:0] CFG_R4 = 3'd7;

    typedef struct packed {
        EnvelopePhase_t phase;
        logic [15:0]    level;
        logic           note;
    } env_state_t;

endpackage

// File: rtl/envelope_update.sv
// Combinational next-phase / next-level computation for one voice operator,
// given its stored state, the current note-on bit and its eight config bytes.
module envelope_update
    import stage_envelope_pkg::*;
(
    input  env_state_t       cur,
    input  logic             note_on,
    input  logic [7:0][7:0]  cfg,
    output env_state_t       nxt
);

    EnvelopePhase_t phase_eff;
    logic [7:0]     lvl_sel;
    logic [7:0]     rate_sel;
    logic [15:0]    target;
    logic [15:0]    step;
    logic [15:0]    diff;
    logic           moving;

    always_comb begin
        phase_eff = cur.phase;
        lvl_sel   = cfg[CFG_L1];
        rate_sel  = cfg[CFG_R1];
        moving    = 1'b1;
        diff      = '0;

        // Note transitions take effect in this same update, before stepping.
        if (note_on && !cur.note) begin
            phase_eff = PHASE_P1;
        end else if (!note_on && (cur.phase inside {PHASE_P1, PHASE_P2, PHASE_P3, PHASE_SUSTAIN})) begin
            phase_eff = PHASE_RELEASE;
        end

        case (phase_eff)
            PHASE_P1: begin
                lvl_sel  = cfg[CFG_L1];
                rate_sel = cfg[CFG_R1];
            end
            PHASE_P2: begin
                lvl_sel  = cfg[CFG_L2];
                rate_sel = cfg[CFG_R2];
            end
            PHASE_P3: begin
                lvl_sel  = cfg[CFG_L3];
                rate_sel = cfg[CFG_R3];
            end
            PHASE_RELEASE: begin
                lvl_sel  = cfg[CFG_L4];
                rate_sel = cfg[CFG_R4];
            end
            default: moving = 1'b0;
        endcase

        target = {lvl_sel, lvl_sel};
        step   = {6'd0, rate_sel, 2'b00};

        nxt.phase = phase_eff;
        nxt.level = cur.level;
        nxt.note  = note_on;

        // A zero rate freezes both the level and the phase.
        if (moving && (step != 16'd0)) begin
            if (cur.level < target) begin
                diff      = target - cur.level;
                nxt.level = (diff <= step) ? target : cur.level + step;
            end else begin
                diff      = cur.level - target;
                nxt.level = (diff <= step) ? target : cur.level - step;
            end

            if (nxt.level == target) begin
                case (phase_eff)
                    PHASE_P1:      nxt.phase = PHASE_P2;
                    PHASE_P2:      nxt.phase = PHASE_P3;
                    PHASE_P3:      nxt.phase = PHASE_SUSTAIN;
                    PHASE_RELEASE: nxt.phase = PHASE_IDLE;
                    default:       nxt.phase = phase_eff;
                endcase
            end
        end
    end

endmodule

// File: rtl/stage_envelope.sv
// Envelope stage: per-voice-operator state and config held in RAM, applied to
// the incoming waveform with a two-cycle latency. STAGE_ENVELOPE_DEBUG_EN adds level/phase outputs.
module stage_envelope
    import stage_envelope_pkg::*;
(
    input  logic             i_Clock,
    input  logic             i_Reset_n,
    input  logic             i_Valid,
    input  VoiceOperatorID_t i_VoiceOperator,
    input  logic [15:0]      i_Waveform,
    input  logic             i_NoteOn,
    input  logic             i_ConfigWriteEnable,
    input  logic [10:0]      i_ConfigWriteAddr,
    input  logic [7:0]       i_ConfigWriteData,
    output logic             o_Ready,
    output logic             o_Valid,
    output VoiceOperatorID_t o_VoiceOperator,
    output logic [15:0]      o_Sample
`ifdef STAGE_ENVELOPE_DEBUG_EN
    ,
    output logic [15:0]      o_EnvelopeLevel,
    output logic [2:0]       o_EnvelopePhase
`endif
);

    logic [7:0]        sweep_reg;
    logic              ready_reg;

    logic              s1_valid_reg;
    VoiceOperatorID_t  s1_id_reg;
    logic [15:0]       s1_wave_reg;
    logic              s1_note_reg;

    env_state_t        state_mem [NUM_VOICE_OPS];
    env_state_t        state_rd_reg;
    logic              state_we;
    VoiceOperatorID_t  state_wa;
    env_state_t        state_wd;

    env_state_t        upd_state;
    logic [7:0][7:0]   cfg_rd;
    logic signed [31:0] product;
    logic [15:0]       sample_next;

    assign o_Ready = ready_reg;

    // Initialisation sweep: one entry per cycle, restarted by every reset.
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            sweep_reg <= '0;
            ready_reg <= 1'b0;
        end else if (!ready_reg) begin
            sweep_reg <= sweep_reg + 8'd1;
            if (sweep_reg == 8'hFF) begin
                ready_reg <= 1'b1;
            end
        end
    end

    always_comb begin
        state_we       = 1'b0;
        state_wa       = sweep_reg;
        state_wd.phase = PHASE_IDLE;
        state_wd.level = 16'd0;
        state_wd.note  = 1'b0;
        if (i_Reset_n) begin
            if (!ready_reg) begin
                state_we = 1'b1;
            end else if (s1_valid_reg) begin
                state_we = 1'b1;
                state_wa = s1_id_reg;
                state_wd = upd_state;
            end
        end
    end

    always_ff @(posedge i_Clock) begin
        if (state_we) begin
            state_mem[state_wa] <= state_wd;
        end
        state_rd_reg <= state_mem[i_VoiceOperator];
    end

    // One config RAM per parameter; a write to the entry being read is passed through.
    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_cfg
            logic [7:0] mem [NUM_VOICE_OPS];
            logic [7:0] rd_reg;
            logic       we;

            assign we = i_ConfigWriteEnable && (i_ConfigWriteAddr[10:8] == 3'(gi));

            always_ff @(posedge i_Clock) begin
                if (we) begin
                    mem[i_ConfigWriteAddr[7:0]] <= i_ConfigWriteData;
                end
                if (we && (i_ConfigWriteAddr[7:0] == i_VoiceOperator)) begin
                    rd_reg <= i_ConfigWriteData;
                end else begin
                    rd_reg <= mem[i_VoiceOperator];
                end
            end

            assign cfg_rd[gi] = rd_reg;
        end
    endgenerate

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            s1_valid_reg <= 1'b0;
        end else begin
            s1_valid_reg <= i_Valid && ready_reg;
        end
        s1_id_reg   <= i_VoiceOperator;
        s1_wave_reg <= i_Waveform;
        s1_note_reg <= i_NoteOn;
    end

    envelope_update u_update (
        .cur     (state_rd_reg),
        .note_on (s1_note_reg),
        .cfg     (cfg_rd),
        .nxt     (upd_state)
    );

    // Level is unsigned, so it gets a zero sign bit before the signed multiply.
    assign product     = $signed(s1_wave_reg) * $signed({1'b0, upd_state.level});
    assign sample_next = 16'(product >>> 16);

    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            o_Valid         <= 1'b0;
            o_VoiceOperator <= '0;
            o_Sample        <= '0;
        end else begin
            o_Valid <= s1_valid_reg;
            if (s1_valid_reg) begin
                o_VoiceOperator <= s1_id_reg;
                o_Sample        <= sample_next;
            end
        end
    end

`ifdef STAGE_ENVELOPE_DEBUG_EN
    always_ff @(posedge i_Clock) begin
        if (!i_Reset_n) begin
            o_EnvelopeLevel <= '0;
            o_EnvelopePhase <= '0;
        end else if (s1_valid_reg) begin
            o_EnvelopeLevel <= upd_state.level;
            o_EnvelopePhase <= upd_state.phase;
        end
    end
`endif

endmodule

// File: tb/tb_stage_envelope.sv
// Directed bench for stage_envelope: reset sweep, envelope phases, clamping,
// zero-rate hold, release/re-trigger, same-cycle config write and reset restart.
module tb_stage_envelope;
    import stage_envelope_pkg::*;

    logic        i_Clock = 1'b0;
    logic        i_Reset_n = 1'b0;
    logic        i_Valid = 1'b0;
    logic [7:0]  i_VoiceOperator = '0;
    logic [15:0] i_Waveform = '0;
    logic        i_NoteOn = 1'b0;
    logic        i_ConfigWriteEnable = 1'b0;
    logic [10:0] i_ConfigWriteAddr = '0;
    logic [7:0]  i_ConfigWriteData = '0;
    logic        o_Ready;
    logic        o_Valid;
    logic [7:0]  o_VoiceOperator;
    logic [15:0] o_Sample;

    int vectors = 0;
    int miscompares = 0;

    always #5 i_Clock = ~i_Clock;

    stage_envelope dut (
        .i_Clock             (i_Clock),
        .i_Reset_n           (i_Reset_n),
        .i_Valid             (i_Valid),
        .i_VoiceOperator     (i_VoiceOperator),
        .i_Waveform          (i_Waveform),
        .i_NoteOn            (i_NoteOn),
        .i_ConfigWriteEnable (i_ConfigWriteEnable),
        .i_ConfigWriteAddr   (i_ConfigWriteAddr),
        .i_ConfigWriteData   (i_ConfigWriteData),
        .o_Ready             (o_Ready),
        .o_Valid             (o_Valid),
        .o_VoiceOperator     (o_VoiceOperator),
        .o_Sample            (o_Sample)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        vectors++;
        assert (obs === want) else begin
            miscompares++;
            $error("FAIL %s: observed %h expected %h", tag, obs, want);
        end
    endtask

    // Entered and left on a falling edge.
    task automatic cfg(input logic [7:0] id, input logic [2:0] p, input logic [7:0] d);
        i_ConfigWriteEnable = 1'b1;
        i_ConfigWriteAddr   = {p, id};
        i_ConfigWriteData   = d;
        @(negedge i_Clock);
        i_ConfigWriteEnable = 1'b0;
    endtask

    task automatic visit_x(input logic [7:0] id, input logic [15:0] wave, input logic note,
                           input logic cw, input logic [10:0] ca, input logic [7:0] cd,
                           input logic [15:0] want, input string tag);
        i_Valid             = 1'b1;
        i_VoiceOperator     = id;
        i_Waveform          = wave;
        i_NoteOn            = note;
        i_ConfigWriteEnable = cw;
        i_ConfigWriteAddr   = ca;
        i_ConfigWriteData   = cd;
        @(negedge i_Clock);
        i_Valid             = 1'b0;
        i_ConfigWriteEnable = 1'b0;
        chk({tag, "/valid_early"}, 32'(o_Valid), 32'd0);
        @(negedge i_Clock);
        chk({tag, "/valid"}, 32'(o_Valid), 32'd1);
        chk({tag, "/id"}, 32'(o_VoiceOperator), 32'(id));
        chk({tag, "/sample"}, 32'(o_Sample), 32'(want));
        @(negedge i_Clock);
        chk({tag, "/valid_pulse"}, 32'(o_Valid), 32'd0);
    endtask

    task automatic visit(input logic [7:0] id, input logic [15:0] wave, input logic note,
                         input logic [15:0] want, input string tag);
        visit_x(id, wave, note, 1'b0, 11'd0, 8'd0, want, tag);
    endtask

    // Counts cycles with o_Ready low, starting at the release edge; i_Valid is
    // held high meanwhile and must never produce o_Valid.
    task automatic wait_ready(input string tag);
        int cnt = 0;
        logic saw_valid = 1'b0;
        i_Valid = 1'b1;
        i_NoteOn = 1'b1;
        while (o_Ready !== 1'b1 && cnt < 400) begin
            if (o_Valid !== 1'b0) saw_valid = 1'b1;
            cnt++;
            @(negedge i_Clock);
        end
        i_Valid = 1'b0;
        i_NoteOn = 1'b0;
        chk({tag, "/not_ready_cycles"}, 32'(cnt), 32'd256);
        chk({tag, "/valid_ignored"}, 32'(saw_valid), 32'd0);
        @(negedge i_Clock);
        @(negedge i_Clock);
        chk({tag, "/valid_after"}, 32'(o_Valid), 32'd0);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1);
    end

    initial begin
        // Reset state, with activity on the inputs.
        i_Valid = 1'b1;
        i_Waveform = 16'h4000;
        i_NoteOn = 1'b1;
        repeat (4) @(negedge i_Clock);
        chk("rst/ready", 32'(o_Ready), 32'd0);
        chk("rst/valid", 32'(o_Valid), 32'd0);
        chk("rst/sample", 32'(o_Sample), 32'd0);
        chk("rst/id", 32'(o_VoiceOperator), 32'd0);
        i_Valid = 1'b0;
        i_Reset_n = 1'b1;
        wait_ready("sweep0");

        // All entries idle with note off: silent output.
        for (int id = 0; id < 256; id++) begin
            visit(8'(id), 16'h7FFF, 1'b0, 16'h0000, "pass0");
        end

        // ID 0: attack with L1=FF/R1=FF, then P2 with zero rate.
        cfg(8'd0, CFG_L1, 8'hFF);
        cfg(8'd0, CFG_R1, 8'hFF);
        cfg(8'd0, CFG_L2, 8'h80);
        cfg(8'd0, CFG_R2, 8'h00);
        cfg(8'd0, CFG_L3, 8'h00);
        cfg(8'd0, CFG_R3, 8'h80);
        cfg(8'd0, CFG_L4, 8'h00);
        cfg(8'd0, CFG_R4, 8'h40);
        visit(8'd0, 16'h4000, 1'b1, 16'h00FF, "id0/first");
        for (int k = 2; k <= 64; k++) begin
            visit(8'd0, 16'h4000, 1'b1, 16'((k * 32'h3FC) >> 2), "id0/attack");
        end
        visit(8'd0, 16'h4000, 1'b1, 16'h3FFF, "id0/clamp");
        for (int k = 0; k < 10; k++) begin
            if (k % 2 == 0) visit(8'd0, 16'h8000, 1'b1, 16'h8000, "id0/hold_neg");
            else            visit(8'd0, 16'h7FFF, 1'b1, 16'h7FFE, "id0/hold_pos");
        end
        // Still in P2: R2 now drives toward 0x8080 by 0x100.
        cfg(8'd0, CFG_R2, 8'h40);
        visit(8'd0, 16'h4000, 1'b1, 16'h3FBF, "id0/p2_resume");
        visit(8'd0, 16'h4000, 1'b0, 16'h3F7F, "id0/release");

        // ID 1: full attack to SUSTAIN, then release to zero.
        cfg(8'd1, CFG_L1, 8'hFF);
        cfg(8'd1, CFG_R1, 8'hFF);
        cfg(8'd1, CFG_L2, 8'hFF);
        cfg(8'd1, CFG_R2, 8'hFF);
        cfg(8'd1, CFG_L3, 8'hFF);
        cfg(8'd1, CFG_R3, 8'hFF);
        cfg(8'd1, CFG_L4, 8'h00);
        cfg(8'd1, CFG_R4, 8'h40);
        for (int k = 1; k <= 64; k++) begin
            visit(8'd1, 16'h4000, 1'b1, 16'((k * 32'h3FC) >> 2), "id1/attack");
        end
        for (int k = 0; k < 4; k++) begin
            visit(8'd1, 16'h4000, 1'b1, 16'h3FFF, "id1/top");
        end
        for (int k = 1; k <= 256; k++) begin
            if (k < 256) visit(8'd1, 16'h4000, 1'b0, 16'((32'hFFFF - k * 32'h100) >> 2), "id1/release");
            else         visit(8'd1, 16'h4000, 1'b0, 16'h0000, "id1/release_end");
        end
        visit(8'd1, 16'h4000, 1'b0, 16'h0000, "id1/idle");
        visit(8'd1, 16'h4000, 1'b1, 16'h00FF, "id1/retrigger");

        // ID 2: stop attack at 0x8000, hold in release (R4=0), re-trigger.
        cfg(8'd2, CFG_L1, 8'hFF);
        cfg(8'd2, CFG_R1, 8'h80);
        cfg(8'd2, CFG_L4, 8'h00);
        cfg(8'd2, CFG_R4, 8'h00);
        for (int k = 1; k <= 64; k++) begin
            visit(8'd2, 16'h4000, 1'b1, 16'((k * 32'h200) >> 2), "id2/attack");
        end
        visit(8'd2, 16'h4000, 1'b0, 16'h2000, "id2/release_hold");
        visit(8'd2, 16'h4000, 1'b0, 16'h2000, "id2/release_hold2");
        visit(8'd2, 16'h4000, 1'b1, 16'h2080, "id2/resume");
        // R1 rewritten to 0x40 in the same cycle as this visit's read.
        visit_x(8'd2, 16'h4000, 1'b1, 1'b1, {CFG_R1, 8'd2}, 8'h40, 16'h20C0, "id2/cfg_same_cycle");
        visit(8'd2, 16'h4000, 1'b1, 16'h2100, "id2/rise");

        // Reset mid-operation, then again mid-sweep.
        i_Reset_n = 1'b0;
        repeat (3) @(negedge i_Clock);
        chk("rst2/ready", 32'(o_Ready), 32'd0);
        chk("rst2/valid", 32'(o_Valid), 32'd0);
        chk("rst2/sample", 32'(o_Sample), 32'd0);
        i_Reset_n = 1'b1;
        repeat (100) @(negedge i_Clock);
        chk("midsweep/ready", 32'(o_Ready), 32'd0);
        i_Reset_n = 1'b0;
        repeat (2) @(negedge i_Clock);
        i_Reset_n = 1'b1;
        wait_ready("sweep2");
        visit(8'd1, 16'h4000, 1'b0, 16'h0000, "post_reset/id1");
        visit(8'd2, 16'h4000, 1'b0, 16'h0000, "post_reset/id2");

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/stage_envelope.md
STAGE_ENVELOPE -- requirements
Module: stage_envelope

Interface
REQ-001 SHALL have no parameters; all sizes are fixed at 32 voices x 8 operators = 256 voice operators.
REQ-002 i_Clock  in  1  sole clock, all logic on rising edge.
REQ-003 i_Reset_n  in  1  reset; synchronous, active-low.
REQ-004 i_Valid  in  1  qualifies i_VoiceOperator/i_Waveform/i_NoteOn this cycle.
REQ-005 i_VoiceOperator  in  8  VoiceOperatorID_t of the sample arriving from waveform generation.
REQ-006 i_Waveform  in  16  signed raw operator waveform sample.
REQ-007 i_NoteOn  in  1  note-on state of the voice owning i_VoiceOperator.
REQ-008 i_ConfigWriteEnable  in  1  envelope config write strobe.
REQ-009 i_ConfigWriteAddr  in  11  {param[2:0], voiceop[7:0]}; param 0-3 = L1-L4, 4-7 = R1-R4.
REQ-010 i_ConfigWriteData  in  8  unsigned level/rate value.
REQ-011 o_Ready  out  1  high once state-memory initialisation is complete.
REQ-012 o_Valid  out  1  i_Valid delayed by the stage latency.
REQ-013 o_VoiceOperator  out  8  i_VoiceOperator delayed by the stage latency.
REQ-014 o_Sample  out  16  signed enveloped sample.

Function
REQ-015 SHALL hold per voice operator: phase (IDLE, P1, P2, P3, SUSTAIN, RELEASE), 16-bit unsigned level, and previous note-on bit.
REQ-016 SHALL have a latency of exactly 2 cycles from i_Valid to o_Valid, with o_VoiceOperator aligned to o_Valid.
REQ-017 SHALL ignore i_Valid while o_Ready=0; o_Valid SHALL stay 0 during that time.
REQ-018 Each valid input SHALL read the entry, compute the next phase/level, write it back, and drive the output using the updated level.
REQ-019 Target for phase n SHALL be {Ln,Ln} (Ln*257); step SHALL be Rn*4.
REQ-020 Level SHALL move toward the target by the step without overshooting; it clamps to the target when within one step.
REQ-021 In the update where level equals the target: P1->P2, P2->P3, P3->SUSTAIN (hold at L3 target), RELEASE->IDLE.
REQ-022 A note-on rising edge (i_NoteOn=1, stored bit 0) from any phase SHALL enter P1 from the current level, without resetting the level.
REQ-023 i_NoteOn=0 in P1/P2/P3/SUSTAIN SHALL enter RELEASE (target L4, rate R4) in the same update.
REQ-024 Rn=0 SHALL hold the level, stalling the phase indefinitely.
REQ-025 IDLE SHALL hold the level unchanged.
REQ-026 o_Sample SHALL be bits [31:16] of signed(i_Waveform) x signed({1'b0,level}).
REQ-027 Config writes SHALL be visible from the next visit of that voice operator, including a write in the same cycle as its read.
REQ-028 Two valid inputs with the same ID less than 3 cycles apart have undefined results; no forwarding is required.

Reset
REQ-029 While i_Reset_n=0: o_Ready=0, o_Valid=0, o_Sample=0, o_VoiceOperator=0.
REQ-030 After release, an 8-bit sweep counter SHALL write IDLE/level 0/note-bit 0 to entries 0..255 over 256 cycles, then set o_Ready=1.
REQ-031 Reasserting reset mid-sweep or mid-operation SHALL restart the sweep from entry 0.
REQ-032 Config memories SHALL NOT be reset; software writes them before use.

Configuration
REQ-033 With STAGE_ENVELOPE_DEBUG_EN defined, the block SHALL add two ports aligned to o_Valid: o_EnvelopeLevel (16-bit level) and o_EnvelopePhase (3-bit phase).
REQ-034 Without STAGE_ENVELOPE_DEBUG_EN defined, those ports and their pipeline registers SHALL be absent and all other behaviour SHALL be unchanged.

Structure
REQ-035 synth.svh package SHALL hold VoiceOperatorID_t, the EnvelopePhase_t enum, and the config param codes 0-7.
REQ-036 Next-phase/next-level computation SHALL be a combinational sub-module, envelope_update; state and config SHALL be stored in inferred RAMs.

Verification
REQ-037 Reset release -> o_Ready=0 for 256 cycles, then 1; first pass of all 256 IDs with note off -> o_Sample=0.
REQ-038 ID 0: L1=FF, R1=FF, waveform 0x4000, note on -> first visit level 0x03FC, o_Sample=0x00FF; visit 65 clamps to 0xFFFF and enters P2.
REQ-039 SUSTAIN at 0xFFFF, L4=00, R4=40, note off -> level drops 0x0100 per visit; reaches 0 on visit 256, then IDLE.
REQ-040 R2=0 after reaching P2 -> level unchanged across 10 visits, phase stays P2.
REQ-041 Level 0xFFFF, waveform 0x8000 -> o_Sample=0x8000; waveform 0x7FFF -> o_Sample=0x7FFE.
REQ-042 Note on, then off, then on during RELEASE at level 0x8000 -> P1 resumes from 0x8000 and rises on the next visit.
